// File: rtl/abus_pkg.sv
// Shared address-bus encodings: base selects and adder modes used by the ABH stage and the microcode ROM.
// Pure constants package, no logic.
package abus_pkg;

   localparam logic [1:0] BASE_ZERO = 2'b00;
   localparam logic [1:0] BASE_PC   = 2'b01;
   localparam logic [1:0] BASE_AH   = 2'b10;
   localparam logic [1:0] BASE_DB   = 2'b11;

   localparam logic [1:0] MODE_ADD   = 2'b00;
   localparam logic [1:0] MODE_REL   = 2'b01;
   localparam logic [1:0] MODE_STACK = 2'b10;
   localparam logic [1:0] MODE_VEC   = 2'b11;

   localparam logic [7:0] STACK_PAGE = 8'h01;
   localparam logic [7:0] VEC_PAGE   = 8'hFF;

endpackage

// File: rtl/abh_inc8.sv
// 8-bit incrementer: O = I + CI, wraps FF->00 without carry out.
// Combinational, zero latency; no backpressure.
module inc8 (
   input  logic [7:0] I,
   input  logic       CI,
   output logic [7:0] O
);

   assign O = I + {7'b0, CI};

endmodule

// File: rtl/abh.sv
// High address byte stage: combinational ADH, registered ABH/AHH/PCH and page-cross flag PX.
// ADH zero latency, registers one cycle; no backpressure, updates every clock.
module abh
   import abus_pkg::*;
#(
   parameter logic [7:0] RESET_AB = 8'h00
) (
   input  logic       clk,
   input  logic       RST_N,
   input  logic       CI,
   input  logic       sign,
   input  logic [7:0] DB,
   input  logic [3:0] op,
   input  logic       ld_ahh,
   input  logic       ld_pc,
   input  logic       pcl_co,
   output logic [7:0] ADH,
   output logic [7:0] ABH,
   output logic [7:0] PCH,
   output logic       PX
);

   logic [7:0] ahh;
   logic [7:0] base;
   logic [7:0] pch_inc;
   logic       px_nxt;

   always_comb begin
      base = 8'h00;
      case (op[3:2])
         BASE_ZERO: base = 8'h00;
         BASE_PC:   base = PCH;
         BASE_AH:   base = ahh;
         BASE_DB:   base = DB;
         default:   base = 8'h00;
      endcase
   end

   // Relative mode adds {8{sign}} (i.e. -1) so a backward branch borrows into the page below.
   always_comb begin
      ADH    = 8'h00;
      px_nxt = 1'b0;
      case (op[1:0])
         MODE_ADD: begin
            ADH    = base + {7'b0, CI};
            px_nxt = CI;
         end
         MODE_REL: begin
            ADH    = ABH + {7'b0, CI} + {8{sign}};
            px_nxt = CI ^ sign;
         end
         MODE_STACK: ADH = STACK_PAGE;
         MODE_VEC:   ADH = VEC_PAGE;
         default: begin
            ADH    = 8'h00;
            px_nxt = 1'b0;
         end
      endcase
   end

   inc8 u_pch_inc (
      .I  (ABH),
      .CI (pcl_co),
      .O  (pch_inc)
   );

   always_ff @(posedge clk or negedge RST_N) begin
      if (!RST_N) begin
         ABH <= RESET_AB;
         ahh <= 8'h00;
         PCH <= 8'h00;
         PX  <= 1'b0;
      end else begin
         ABH <= ADH;
         PX  <= px_nxt;
         if (ld_ahh) ahh <= DB;
         if (ld_pc)  PCH <= pch_inc;
      end
   end

endmodule

// File: tb/tb_abh.sv
// Directed bench for abh: an arithmetic reference model checked every cycle, plus literal expectations.
module tb_abh;

   logic       clk = 1'b0;
   logic       RST_N = 1'b0;
   logic       CI = 1'b0;
   logic       sign = 1'b0;
   logic [7:0] DB = 8'h00;
   logic [3:0] op = 4'h0;
   logic       ld_ahh = 1'b0;
   logic       ld_pc = 1'b0;
   logic       pcl_co = 1'b0;
   logic [7:0] ADH, ABH, PCH;
   logic       PX;

   int n_checks = 0;
   int n_fail   = 0;

   int m_abh = 0;
   int m_ahh = 0;
   int m_pch = 0;
   int m_px  = 0;

   abh #(.RESET_AB(8'h00)) dut (
      .clk    (clk),
      .RST_N  (RST_N),
      .CI     (CI),
      .sign   (sign),
      .DB     (DB),
      .op     (op),
      .ld_ahh (ld_ahh),
      .ld_pc  (ld_pc),
      .pcl_co (pcl_co),
      .ADH    (ADH),
      .ABH    (ABH),
      .PCH    (PCH),
      .PX     (PX)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int model_adh();
      int b;
      case (int'(op[3:2]))
         0:       b = 0;
         1:       b = m_pch;
         2:       b = m_ahh;
         default: b = int'(DB);
      endcase
      case (int'(op[1:0]))
         0:       return (b + int'(CI)) % 256;
         1:       return (m_abh + int'(CI) - int'(sign) + 256) % 256;
         2:       return 1;
         default: return 255;
      endcase
   endfunction

   function automatic int model_px();
      case (int'(op[1:0]))
         0:       return int'(CI);
         1:       return ((int'(CI) - int'(sign)) != 0) ? 1 : 0;
         default: return 0;
      endcase
   endfunction

   always @(posedge clk or negedge RST_N) begin
      if (!RST_N) begin
         m_abh = 0; m_ahh = 0; m_pch = 0; m_px = 0;
      end else begin
         int n_abh, n_ahh, n_pch, n_px;
         n_abh = model_adh();
         n_px  = model_px();
         n_ahh = ld_ahh ? int'(DB) : m_ahh;
         n_pch = ld_pc ? (m_abh + int'(pcl_co)) % 256 : m_pch;
         m_abh = n_abh; m_ahh = n_ahh; m_pch = n_pch; m_px = n_px;
      end
   end

   always @(negedge clk) begin
      if (RST_N) begin
         check("adh_model", int'(ADH), model_adh());
         check("abh_model", int'(ABH), m_abh);
         check("pch_model", int'(PCH), m_pch);
         check("px_model",  int'(PX),  m_px);
      end
   end

   task automatic step(input logic [3:0] o, input logic [7:0] d, input logic c,
                       input logic s, input logic la, input logic lp, input logic pc);
      op = o; DB = d; CI = c; sign = s; ld_ahh = la; ld_pc = lp; pcl_co = pc;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2;
      check("rst_abh", int'(ABH), 8'h00);
      check("rst_pch", int'(PCH), 8'h00);
      check("rst_px",  int'(PX),  0);
      check("rst_adh", int'(ADH), 8'h00);
      @(posedge clk);
      #1;
      RST_N = 1'b1;

      // Absolute indexed: load AHH then add carry.
      step(4'b0000, 8'h12, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      op = 4'b1000; CI = 1'b1; ld_ahh = 1'b0; #1;
      check("abs_adh_comb", int'(ADH), 8'h13);
      step(4'b1000, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      check("abs_cross_abh", int'(ABH), 8'h13);
      check("abs_cross_px",  int'(PX),  1);
      step(4'b1000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("abs_nocross_abh", int'(ABH), 8'h12);
      check("abs_nocross_px",  int'(PX),  0);

      // Backward branches.
      step(4'b1100, 8'h40, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(4'b0001, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      check("bra_back_abh", int'(ABH), 8'h3F);
      check("bra_back_px",  int'(PX),  1);
      step(4'b1100, 8'h40, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(4'b0101, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      check("bra_stay_abh", int'(ABH), 8'h40);
      check("bra_stay_px",  int'(PX),  0);

      // Stack and vector pages.
      step(4'b0010, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      check("stack_abh", int'(ABH), 8'h01);
      check("stack_px",  int'(PX),  0);
      step(4'b1111, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      check("vec_abh", int'(ABH), 8'hFF);
      check("vec_px",  int'(PX),  0);

      // PC load and wrap.
      step(4'b0011, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("pc_load_ff", int'(PCH), 8'hFF);
      step(4'b0011, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      check("pc_wrap", int'(PCH), 8'h00);
      step(4'b1100, 8'h7A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(4'b1100, 8'h7A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      check("pc_inc", int'(PCH), 8'h7B);
      step(4'b1100, 8'h7A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check("pc_hold_co1", int'(PCH), 8'h7B);
      step(4'b1100, 8'h7A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("pc_hold_co0", int'(PCH), 8'h7B);

      // PCH used as base while being reloaded.
      step(4'b0100, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("pc_coll_abh", int'(ABH), 8'h7B);
      check("pc_coll_pch", int'(PCH), 8'h7A);

      // AHH used as base while being reloaded.
      step(4'b1100, 8'h20, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      step(4'b1000, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      check("ahh_coll_abh", int'(ABH), 8'h20);
      step(4'b1000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("ahh_new_abh", int'(ABH), 8'h55);

      // Asynchronous reset mid-stream.
      step(4'b1100, 8'h3B, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      check("pre_rst_abh", int'(ABH), 8'h3C);
      check("pre_rst_px",  int'(PX),  1);
      op = 4'b1000; CI = 1'b0; ld_pc = 1'b0;
      #2;
      RST_N = 1'b0;
      #1;
      check("arst_abh", int'(ABH), 8'h00);
      check("arst_pch", int'(PCH), 8'h00);
      check("arst_px",  int'(PX),  0);
      check("arst_adh_ahh", int'(ADH), 8'h00);
      @(posedge clk);
      #1;
      RST_N = 1'b1;
      step(4'b0100, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      check("post_rst_abh", int'(ABH), 8'h01);
      check("post_rst_px",  int'(PX),  1);

      @(posedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/abh.md
# abh

Address Bus High stage of the 65C02 address generator. It sits directly downstream of the low-byte stage: it consumes that stage's carry out and PCL carry, and produces the high address byte (registered ABH and unregistered ADH). It also holds the Address Hold High (AHH) and Program Counter High (PCH) registers, and flags page crossings so the microcode can insert a fix-up cycle.

## Interface
Parameters:
- `RESET_AB`, default 8'h00: reset value of the ABH register.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `RST_N`  in  1  asynchronous, active-low reset.
- `CI`  in  1  carry from the low-byte adder; same cycle as `op`.
- `sign`  in  1  branch offset sign (DB[7] of the relative operand); used in mode 01 only.
- `DB`  in  8  data bus.
- `op`  in  4  operation: `op[3:2]` selects the base, `op[1:0]` selects the mode.
- `ld_ahh`  in  1  load AHH from DB.
- `ld_pc`  in  1  load PCH.
- `pcl_co`  in  1  carry out of the PCL incrementer.
- `ADH`  out  8  unregistered next high address byte.
- `ABH`  out  8  registered high address byte.
- `PCH`  out  8  program counter, high byte.
- `PX`  out  1  page-cross flag, registered.

## Operation
- Base select, from `op[3:2]`:
  - 00 selects 8'h00.
  - 01 selects PCH.
  - 10 selects AHH.
  - 11 selects DB.
- Mode, from `op[1:0]`. All sums are modulo 256.
  - 00: ADH = base + CI.
  - 01: ADH = ABH + CI + {8{sign}}, i.e. ABH + CI − sign. This is the branch or stay-on-page case; the base is ignored.
  - 10: ADH = 8'h01 (stack page). CI is ignored.
  - 11: ADH = 8'hFF (vector page). CI is ignored.
- ABH is loaded from ADH on every edge.
- AHH is loaded from DB on the edge when `ld_ahh` = 1; otherwise it holds.
- PCH is loaded from ABH + `pcl_co` on the edge when `ld_pc` = 1; otherwise it holds. It wraps FF→00 with no carry out.
- PX is updated every cycle:
  - mode 00: PX <= CI.
  - mode 01: PX <= CI ^ sign.
  - modes 10 and 11: PX <= 0.
- Simultaneous events:
  - `ld_ahh` together with base=AHH: ADH uses the old AHH value.
  - `ld_pc` together with base=PCH: ADH uses the old PCH value; the new PCH is computed from the old ABH.
- No state machine beyond the registers. Sequencing is owned by the microcode.

## Timing
- ADH is combinational from `op`, `CI`, `sign`, DB and the registers. It is valid in the same cycle as its inputs, with zero latency.
- ABH, PCH, AHH and PX have one-cycle latency: they show the new value after the rising edge.
- `pcl_co` must be derived from the same-cycle registered ABL, so PCH and PCL update on the same edge.
- Reset, asynchronous and active-low, at any time including mid-instruction:
  - ABH = `RESET_AB`.
  - AHH = 8'h00.
  - PCH = 8'h00.
  - PX = 0.
  - ADH follows combinationally from the reset register values.
- On RST_N deassertion, the first edge performs a normal update. There is no extra reset-recovery cycle.

## Structure
- Shared package `abus_pkg` holds the base-select constants (BASE_ZERO, BASE_PC, BASE_AH, BASE_DB) and the mode constants (MODE_ADD, MODE_REL, MODE_STACK, MODE_VEC). The microcode ROM generator uses the same constants.
- The PCH update reuses the existing `inc8` sub-module: I=ABH, CI=`pcl_co`, O feeds the PCH register.
- AHH, ABH and PCH are 8-bit enabled registers with async active-low clear. PX is a 1-bit flop.

## Test plan
- Reset: assert RST_N=0 mid-stream with ABH=8'h3C. Required: ABH=00, PCH=00, AHH=00 and PX=0 immediately, without waiting for a clock edge.
- Absolute indexed page cross: load AHH=8'h12 via `ld_ahh`, then op={10,00} with CI=1. Required: ADH=13 combinationally; ABH=13 and PX=1 after the edge. Repeat with CI=0: ABH=12, PX=0.
- Backward branch: with ABH=8'h40, apply op={xx,01}, sign=1, CI=0. Required: ABH=3F, PX=1. With sign=1, CI=1: ABH=40, PX=0.
- Stack and vector: apply mode 10, then mode 11, with CI=1. Required: ABH=01 then FF, PX=0 both times.
- PC wrap: with ABH=8'hFF, assert `ld_pc`=1 and `pcl_co`=1. Required: PCH=00. With `ld_pc`=0, PCH holds regardless of `pcl_co`.
- Same-cycle AHH collision: with AHH=8'h20, assert `ld_ahh`=1, DB=8'h55 and op={10,00}, CI=0. Required: ABH=20 this edge, AHH=55 afterwards.
